// File: rtl/alu_pkg.sv
// Shared definitions for the ALU decode/issue stage: ALU control codes,
// RV32I opcode constants, operand-select codes and the command record that
// travels from the decoder through the skid buffer to the execute stage.
package alu_pkg;

  localparam int XLEN = 32;

  // ALU control codes presented on aluctrl
  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;
  localparam logic [3:0] ALU_SLL = 4'd6;
  localparam logic [3:0] ALU_SRL = 4'd7;
  localparam logic [3:0] ALU_SRA = 4'd8;

  // RV32I major opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // funct7 values that select the base or alternate (SUB/SRA) operation
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // src1 operand selects
  localparam logic [1:0] SRC1_RS1  = 2'd0;
  localparam logic [1:0] SRC1_PC   = 2'd1;
  localparam logic [1:0] SRC1_ZERO = 2'd2;

  typedef struct packed {
    logic [3:0]      aluctrl;
    logic [1:0]      src1_sel;
    logic            src2_imm;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } alu_cmd_t;

  // Idle command shown on the outputs after reset: ADD, everything else zero
  function automatic alu_cmd_t idle_cmd();
    alu_cmd_t cmd;
    cmd         = '0;
    cmd.aluctrl = ALU_ADD;
    return cmd;
  endfunction

  // Shared funct3 -> ALU op map for OP and OP-IMM; alt picks SUB/SRA.
  // funct3 011 (SLTU) is unsupported and filtered out by the caller.
  function automatic logic [3:0] f3_to_aluctrl(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_cmd_skid.sv
// Two-entry skid buffer for alu_cmd_t. The head entry drives the outputs
// directly so the command is registered; in_ready is a registered !full so it
// never combinationally depends on out_ready. flush empties the buffer while
// the head register keeps showing its last contents.
module alu_cmd_skid
  import alu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     flush,
  input  logic     in_valid,
  output logic     in_ready,
  input  alu_cmd_t in_cmd,
  output logic     out_valid,
  input  logic     out_ready,
  output alu_cmd_t out_cmd
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  logic [1:0] count_q;
  logic [1:0] count_next;
  logic       in_ready_q;
  alu_cmd_t   head_q;
  alu_cmd_t   tail_q;
  logic       push;
  logic       pop;

  assign push      = in_valid && in_ready_q;
  assign pop       = (count_q != 2'd0) && out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = (count_q != 2'd0);
  assign out_cmd   = head_q;

  // Next occupancy: flush wins over any push/pop in the same cycle
  always_comb begin
    // NOTE: default first so every path assigns count_next and no latch is inferred.
    count_next = count_q;
    if (flush) begin
      count_next = 2'd0;
    end else if (push && !pop) begin
      count_next = count_q + 2'd1;
    end else if (pop && !push) begin
      count_next = count_q - 2'd1;
    end
  end

  // Occupancy, registered ready and the head (output) entry
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      count_q    <= 2'd0;
      in_ready_q <= 1'b0;
      head_q     <= idle_cmd();
    end else begin
      count_q    <= count_next;
      in_ready_q <= (count_next != FULL);
      if (!flush) begin
        if (push && ((count_q == 2'd0) || ((count_q == 2'd1) && pop))) begin
          head_q <= in_cmd;
        end else if (pop && (count_q == FULL)) begin
          head_q <= tail_q;
        end
      end
    end
  end

  // Second (skid) entry, written only when the head is occupied and stays put
  always_ff @(posedge clk) begin
    // NOTE: no reset on this storage; it is only read while count_q says it holds valid data.
    if (!flush && push && (count_q == 2'd1) && !pop) begin
      tail_q <= in_cmd;
    end
  end

endmodule

// File: rtl/alu_op_decoder.sv
// RV32I decode/issue stage: decodes the instruction word into an ALU command
// (control code, operand selects, immediate, register indices, pc) and queues
// it in a 2-entry skid buffer, giving one cycle of latency to the ALU.
// Optional build macro: ALU_DEC_ILLEGAL_EN -- when defined, unsupported
// encodings are flagged on the illegal output; otherwise illegal is always 0.
module alu_op_decoder
  import alu_pkg::*;
#(
  parameter int XLEN  = alu_pkg::XLEN,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      aluctrl,
  output logic [1:0]      src1_sel,
  output logic            src2_imm,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] pc_out,
  output logic            illegal
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd_f;
  logic [4:0]  rs1_f;
  logic [4:0]  rs2_f;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_sh;
  logic        bad;
  alu_cmd_t    dec_cmd;
  alu_cmd_t    out_cmd;

  assign opcode = instr[6:0];
  assign rd_f   = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1_f  = instr[19:15];
  assign rs2_f  = instr[24:20];
  assign f7     = instr[31:25];

  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_sh = {27'b0, instr[24:20]};

  // Combinational decode of the offered instruction into a buffer entry
  always_comb begin
    dec_cmd         = '0;
    dec_cmd.aluctrl = ALU_ADD;
    dec_cmd.pc      = pc;
    bad             = 1'b0;

    case (opcode)
      OP_R: begin
        dec_cmd.rs1 = rs1_f;
        dec_cmd.rs2 = rs2_f;
        dec_cmd.rd  = rd_f;
        if (f3 == 3'b011) begin
          bad = 1'b1;
        end else if (f7 == F7_BASE) begin
          dec_cmd.aluctrl = f3_to_aluctrl(f3, 1'b0);
        end else if ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))) begin
          dec_cmd.aluctrl = f3_to_aluctrl(f3, 1'b1);
        end else begin
          bad = 1'b1;
        end
      end

      OP_I: begin
        dec_cmd.rs1      = rs1_f;
        dec_cmd.rd       = rd_f;
        dec_cmd.src2_imm = 1'b1;
        dec_cmd.imm      = imm_i;
        case (f3)
          3'b011: bad = 1'b1;
          3'b001: begin
            dec_cmd.imm = imm_sh;
            if (f7 == F7_BASE) dec_cmd.aluctrl = ALU_SLL;
            else               bad = 1'b1;
          end
          3'b101: begin
            dec_cmd.imm = imm_sh;
            if (f7 == F7_BASE)     dec_cmd.aluctrl = ALU_SRL;
            else if (f7 == F7_ALT) dec_cmd.aluctrl = ALU_SRA;
            else                   bad = 1'b1;
          end
          // ADDI has no SUB form: upper immediate bits are data, not funct7
          default: dec_cmd.aluctrl = f3_to_aluctrl(f3, 1'b0);
        endcase
      end

      OP_LOAD, OP_JALR: begin
        dec_cmd.rs1      = rs1_f;
        dec_cmd.rd       = rd_f;
        dec_cmd.src2_imm = 1'b1;
        dec_cmd.imm      = imm_i;
      end

      OP_STORE: begin
        dec_cmd.rs1      = rs1_f;
        dec_cmd.rs2      = rs2_f;
        dec_cmd.src2_imm = 1'b1;
        dec_cmd.imm      = imm_s;
      end

      // Branches compare via the ALU: SUB for the zero flag, SLT for ordering
      OP_BRANCH: begin
        dec_cmd.rs1 = rs1_f;
        dec_cmd.rs2 = rs2_f;
        dec_cmd.imm = imm_b;
        case (f3)
          3'b000, 3'b001: dec_cmd.aluctrl = ALU_SUB;
          3'b100, 3'b101: dec_cmd.aluctrl = ALU_SLT;
          default:        bad = 1'b1;
        endcase
      end

      OP_LUI: begin
        dec_cmd.src1_sel = SRC1_ZERO;
        dec_cmd.src2_imm = 1'b1;
        dec_cmd.imm      = imm_u;
        dec_cmd.rd       = rd_f;
      end

      OP_AUIPC: begin
        dec_cmd.src1_sel = SRC1_PC;
        dec_cmd.src2_imm = 1'b1;
        dec_cmd.imm      = imm_u;
        dec_cmd.rd       = rd_f;
      end

      // JAL uses the ALU to form the link value pc+4
      OP_JAL: begin
        dec_cmd.src1_sel = SRC1_PC;
        dec_cmd.src2_imm = 1'b1;
        dec_cmd.imm      = 32'd4;
        dec_cmd.rd       = rd_f;
      end

      default: bad = 1'b1;
    endcase

    // Unsupported encodings become a harmless ADD that writes nothing
    if (bad) begin
      dec_cmd          = '0;
      dec_cmd.aluctrl  = ALU_ADD;
      dec_cmd.pc       = pc;
    end

`ifdef ALU_DEC_ILLEGAL_EN
    dec_cmd.illegal = bad;
`else
    dec_cmd.illegal = 1'b0;
`endif
  end

  alu_cmd_skid #(
    .DEPTH (DEPTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_cmd    (dec_cmd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_cmd   (out_cmd)
  );

  assign aluctrl  = out_cmd.aluctrl;
  assign src1_sel = out_cmd.src1_sel;
  assign src2_imm = out_cmd.src2_imm;
  assign imm      = out_cmd.imm;
  assign rs1      = out_cmd.rs1;
  assign rs2      = out_cmd.rs2;
  assign rd       = out_cmd.rd;
  assign pc_out   = out_cmd.pc;
  assign illegal  = out_cmd.illegal;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Directed bench for alu_op_decoder: inputs change and outputs are sampled on
// the falling edge, away from the rising edge that updates the design.
module tb_alu_op_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  aluctrl;
  logic [1:0]  src1_sel;
  logic        src2_imm;
  logic [31:0] imm;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] pc_out;
  logic        illegal;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_op_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .pc        (pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .aluctrl   (aluctrl),
    .src1_sel  (src1_sel),
    .src2_imm  (src2_imm),
    .imm       (imm),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .pc_out    (pc_out),
    .illegal   (illegal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Offer one instruction for exactly one rising edge, return at the next falling edge
  task automatic send(input logic [31:0] i, input logic [31:0] p);
    instr    = i;
    pc       = p;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Check the presented command against hand-decoded values
  task automatic expect_cmd(input string tag, input logic [3:0] e_ctrl, input logic [1:0] e_s1,
                            input logic e_s2i, input logic [31:0] e_imm, input logic [4:0] e_rd);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    check({tag, ".aluctrl"},   32'(aluctrl),   32'(e_ctrl));
    check({tag, ".src1_sel"},  32'(src1_sel),  32'(e_s1));
    check({tag, ".src2_imm"},  32'(src2_imm),  32'(e_s2i));
    check({tag, ".imm"},       imm,            e_imm);
    check({tag, ".rd"},        32'(rd),        32'(e_rd));
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    instr     = 32'h0;
    pc        = 32'h0;
    out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.in_ready",  32'(in_ready),  32'd0);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.aluctrl",   32'(aluctrl),   32'd2);
    check("rst.imm",       imm,            32'd0);
    check("rst.rd",        32'(rd),        32'd0);
    check("rst.src1_sel",  32'(src1_sel),  32'd0);
    check("rst.illegal",   32'(illegal),   32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst.in_ready",  32'(in_ready),  32'd1);
    check("post_rst.out_valid", 32'(out_valid), 32'd0);

    // add x3,x1,x2
    send(32'h002081B3, 32'h0000_0100);
    expect_cmd("add", 4'd2, 2'd0, 1'b0, 32'd0, 5'd3);
    check("add.rs1",     32'(rs1), 32'd1);
    check("add.rs2",     32'(rs2), 32'd2);
    check("add.pc_out",  pc_out,   32'h0000_0100);

    // sub x0,x1,x2
    send(32'h40208033, 32'h0000_0104);
    expect_cmd("sub", 4'd3, 2'd0, 1'b0, 32'd0, 5'd0);

    // srai x4,x2,3 then srli x4,x2,3 (back-to-back: accept and consume together)
    send(32'h40315213, 32'h0000_0108);
    expect_cmd("srai", 4'd8, 2'd0, 1'b1, 32'd3, 5'd4);
    send(32'h00315213, 32'h0000_010C);
    expect_cmd("srli", 4'd7, 2'd0, 1'b1, 32'd3, 5'd4);
    check("srli.pc_out", pc_out, 32'h0000_010C);

    // addi x1,x0,-1 : full sign extension
    send(32'hFFF00093, 32'h0000_0110);
    expect_cmd("addi_neg", 4'd2, 2'd0, 1'b1, 32'hFFFF_FFFF, 5'd1);

    // beq x1,x2,-4
    send(32'hFE208EE3, 32'h0000_0114);
    expect_cmd("beq", 4'd3, 2'd0, 1'b0, 32'hFFFF_FFFC, 5'd0);

    // lui x0,0x12345
    send(32'h12345037, 32'h0000_0118);
    expect_cmd("lui", 4'd2, 2'd2, 1'b1, 32'h1234_5000, 5'd0);

    // sw x2,8(x1)
    send(32'h0020A423, 32'h0000_011C);
    expect_cmd("sw", 4'd2, 2'd0, 1'b1, 32'd8, 5'd0);

    // jal x1,0 : link value pc+4
    send(32'h000000EF, 32'h0000_0120);
    expect_cmd("jal", 4'd2, 2'd1, 1'b1, 32'd4, 5'd1);

    // sltu x3,x1,x2 : unsupported
    send(32'h0020B1B3, 32'h0000_0124);
`ifdef ALU_DEC_ILLEGAL_EN
    check("sltu.illegal", 32'(illegal), 32'd1);
`else
    check("sltu.illegal", 32'(illegal), 32'd0);
`endif
    expect_cmd("sltu", 4'd2, 2'd0, 1'b0, 32'd0, 5'd0);

    // add with funct7=0000001 : bad f7
    send(32'h022081B3, 32'h0000_0128);
    expect_cmd("bad_f7", 4'd2, 2'd0, 1'b0, 32'd0, 5'd0);

    // Drain, then back-pressure: three offered, two accepted
    @(negedge clk);
    check("drain.out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    instr = 32'h00100093; pc = 32'h200; in_valid = 1'b1;   // addi x1,x0,1
    @(negedge clk);
    check("bp.in_ready_1", 32'(in_ready), 32'd1);
    instr = 32'h00200113; pc = 32'h204;                     // addi x2,x0,2
    @(negedge clk);
    check("bp.in_ready_full", 32'(in_ready), 32'd0);
    check("bp.head_rd",       32'(rd),       32'd1);
    instr = 32'h00300193; pc = 32'h208;                     // addi x3,x0,3 (refused)
    @(negedge clk);
    check("bp.still_full",    32'(in_ready), 32'd0);
    check("bp.head_stable",   32'(rd),       32'd1);
    check("bp.head_imm",      imm,           32'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp.second_valid", 32'(out_valid), 32'd1);
    check("bp.second_rd",    32'(rd),        32'd2);
    check("bp.second_pc",    pc_out,         32'h204);
    check("bp.ready_again",  32'(in_ready),  32'd1);
    @(negedge clk);
    check("bp.empty",        32'(out_valid), 32'd0);
    check("bp.hold_rd",      32'(rd),        32'd2);

    // Fill, then flush with a new instruction offered in the same cycle
    out_ready = 1'b0;
    send(32'h00400213, 32'h300);                            // addi x4,x0,4
    send(32'h00500293, 32'h304);                            // addi x5,x0,5
    check("fl.full", 32'(in_ready), 32'd0);
    flush = 1'b1;
    instr = 32'h00600313; pc = 32'h308; in_valid = 1'b1;    // addi x6,x0,6 (dropped)
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl.out_valid", 32'(out_valid), 32'd0);
    check("fl.in_ready",  32'(in_ready),  32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    check("fl.stays_empty", 32'(out_valid), 32'd0);

    // Normal flow resumes after the flush
    send(32'h0020F3B3, 32'h400);                            // and x7,x1,x2
    expect_cmd("and_after_flush", 4'd0, 2'd0, 1'b0, 32'd0, 5'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
